// File: rtl/cb_douta_ctrl.sv
// cb_douta_ctrl: CB port-A read sequencer with lane-mapper select aligned to read latency.
// Ports:
//   i_clk, i_sys_rst_n          clock, synchronous active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake (ready only while idle)
//   i_cmd_target, i_cmd_dir     mapper target and direction codes
//   i_cmd_base, i_cmd_len       first read address and number of rows (0 = no-op)
//   i_cmd_l_k_0                 landmark index LSB, held on o_l_k_0 until the next accept
//   i_abort                     cancels an active command (issue or drain)
//   o_cb_ena, o_cb_addra        CB port-A read enable and address
//   o_seq_cnt_out               row index of the current read issue
//   o_cb_douta_sel              {target,dir} delayed by RD_LAT to meet the returning data
//   o_busy, o_done              command in flight, one-cycle completion pulse
module cb_douta_ctrl #(
    parameter int L               = 4,
    parameter int RSA_DW          = 32,
    parameter int SEQ_CNT_DW      = 5,
    parameter int CB_DOUTA_SEL_DW = 5,
    parameter int CB_AW           = 10,
    parameter int RD_LAT          = 2
) (
    input  logic                       i_clk,
    input  logic                       i_sys_rst_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [2:0]                 i_cmd_target,
    input  logic [1:0]                 i_cmd_dir,
    input  logic [CB_AW-1:0]           i_cmd_base,
    input  logic [SEQ_CNT_DW-1:0]      i_cmd_len,
    input  logic                       i_cmd_l_k_0,
    input  logic                       i_abort,
    output logic                       o_cb_ena,
    output logic [CB_AW-1:0]           o_cb_addra,
    output logic [SEQ_CNT_DW-1:0]      o_seq_cnt_out,
    output logic [CB_DOUTA_SEL_DW-1:0] o_cb_douta_sel,
    output logic                       o_l_k_0,
    output logic                       o_busy,
    output logic                       o_done
);
    if (L < 1 || RSA_DW < 1 || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_param
        $error("cb_douta_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                     r_state;
    logic [2:0]                 r_target;
    logic [1:0]                 r_dir;
    logic [SEQ_CNT_DW-1:0]      r_len;
    logic [2:0]                 r_drain;
    logic [CB_DOUTA_SEL_DW-1:0] r_sel_pipe [RD_LAT];

    logic [SEQ_CNT_DW-1:0]      w_eff_len;
    logic [CB_DOUTA_SEL_DW-1:0] w_sel_in;
    logic                       w_last;

    // TBa/NEW always walks the fixed five landmark rows
    assign w_eff_len      = (i_cmd_target == 3'b100 && i_cmd_dir == 2'b11) ? SEQ_CNT_DW'(5) : i_cmd_len;
    // only cycles that actually issued a read carry a select down the pipe
    assign w_sel_in       = o_cb_ena ? CB_DOUTA_SEL_DW'({r_target, r_dir}) : '0;
    assign w_last         = o_seq_cnt_out == r_len - SEQ_CNT_DW'(1);
    assign o_cb_douta_sel = r_sel_pipe[RD_LAT-1];
    assign o_cmd_ready    = r_state == S_IDLE;
    assign o_busy         = r_state == S_ISSUE || r_state == S_DRAIN;

    always_ff @(posedge i_clk) begin
        if (!i_sys_rst_n) begin
            r_state       <= S_IDLE;
            r_target      <= '0;
            r_dir         <= '0;
            r_len         <= '0;
            r_drain       <= '0;
            o_cb_ena      <= 1'b0;
            o_cb_addra    <= '0;
            o_seq_cnt_out <= '0;
            o_l_k_0       <= 1'b0;
            o_done        <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) r_sel_pipe[i] <= '0;
        end else begin
            r_sel_pipe[0] <= w_sel_in;
            for (int i = 1; i < RD_LAT; i++) r_sel_pipe[i] <= r_sel_pipe[i-1];
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_target <= i_cmd_target;
                        r_dir    <= i_cmd_dir;
                        r_len    <= w_eff_len;
                        o_l_k_0  <= i_cmd_l_k_0;
                        if (w_eff_len == '0) begin
                            r_state <= S_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            o_cb_ena      <= 1'b1;
                            o_cb_addra    <= i_cmd_base;
                            o_seq_cnt_out <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_abort || w_last) begin
                        r_state       <= i_abort ? S_IDLE : S_DRAIN;
                        r_drain       <= 3'(RD_LAT - 1);
                        o_cb_ena      <= 1'b0;
                        o_cb_addra    <= '0;
                        o_seq_cnt_out <= '0;
                    end else begin
                        o_cb_addra    <= o_cb_addra + CB_AW'(1);
                        o_seq_cnt_out <= o_seq_cnt_out + SEQ_CNT_DW'(1);
                    end
                    if (i_abort) for (int i = 0; i < RD_LAT; i++) r_sel_pipe[i] <= '0;
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        for (int i = 0; i < RD_LAT; i++) r_sel_pipe[i] <= '0;
                    end else if (r_drain == '0) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 3'd1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cb_douta_ctrl.sv
// tb_cb_douta_ctrl: cycle-indexed expectation model plus directed literal checks for cb_douta_ctrl.
module tb_cb_douta_ctrl;
    localparam int RD_LAT = 2;
    localparam int CB_AW  = 10;
    localparam int MAXC   = 600;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0, lk_in = 1'b0;
    logic [2:0] tgt = '0;
    logic [1:0] dir = '0;
    logic [9:0] base = '0;
    logic [4:0] len = '0;
    logic       cmd_ready, cb_ena, l_k_0, busy, done;
    logic [9:0] cb_addra;
    logic [4:0] seq_cnt, sel;

    cb_douta_ctrl #(.L(4), .RSA_DW(32), .SEQ_CNT_DW(5), .CB_DOUTA_SEL_DW(5), .CB_AW(CB_AW), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_sys_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_target(tgt), .i_cmd_dir(dir), .i_cmd_base(base), .i_cmd_len(len),
        .i_cmd_l_k_0(lk_in), .i_abort(abort), .o_cb_ena(cb_ena), .o_cb_addra(cb_addra),
        .o_seq_cnt_out(seq_cnt), .o_cb_douta_sel(sel), .o_l_k_0(l_k_0), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int e_ena[MAXC], e_addr[MAXC], e_seq[MAXC], e_sel[MAXC], e_done[MAXC];
    int e_busy[MAXC], e_ready[MAXC], e_lk[MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expectations per cycle: a command accepted in cycle t reads rows in t+1..t+n,
    // its selects appear RD_LAT later, done follows the drain.
    task automatic m_accept(input int t, input int tg, input int dr, input int bs, input int ln, input int lk);
        int n, d;
        n = (tg == 4 && dr == 3) ? 5 : ln;
        for (int c = t + 1; c < MAXC; c++) e_lk[c] = lk;
        if (n == 0) begin
            e_done[t+1]  = 1;
            e_ready[t+1] = 0;
        end else begin
            for (int k = 0; k < n; k++) begin
                e_ena[t+1+k]  = 1;
                e_addr[t+1+k] = (bs + k) % (1 << CB_AW);
                e_seq[t+1+k]  = k;
                e_sel[t+1+k+RD_LAT] = tg * 4 + dr;
            end
            d = t + n + RD_LAT + 1;
            for (int c = t + 1; c < d; c++) e_busy[c] = 1;
            for (int c = t + 1; c <= d; c++) e_ready[c] = 0;
            e_done[d] = 1;
        end
    endtask

    task automatic m_flush(input int a);
        for (int c = a + 1; c < MAXC; c++) begin
            e_ena[c] = 0; e_addr[c] = 0; e_seq[c] = 0; e_sel[c] = 0;
            e_done[c] = 0; e_busy[c] = 0; e_ready[c] = 1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 2 && cyc < MAXC) begin
            chk("ready", cmd_ready, e_ready[cyc]);
            chk("ena", cb_ena, e_ena[cyc]);
            chk("addra", cb_addra, e_addr[cyc]);
            chk("seq", seq_cnt, e_seq[cyc]);
            chk("sel", sel, e_sel[cyc]);
            chk("done", done, e_done[cyc]);
            chk("busy", busy, e_busy[cyc]);
            chk("lk0", l_k_0, e_lk[cyc]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!e_ready[cyc] && g < 50) begin
            step();
            g++;
        end
        if (g >= 50) begin
            total++;
            bad++;
            $display("FAIL wait_ready timeout cyc=%0d", cyc);
        end
    endtask

    task automatic cmd(input int tg, input int dr, input int bs, input int ln, input int lk, input int ab, output int t);
        wait_ready();
        tgt = tg[2:0]; dir = dr[1:0]; base = bs[9:0]; len = ln[4:0];
        lk_in = lk[0]; abort = ab[0]; cmd_valid = 1'b1;
        t = cyc;
        m_accept(t, tg, dr, bs, ln, lk);
        step();
        cmd_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        if (e_busy[cyc] != 0) m_flush(cyc);
        step();
        abort = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_flush(cyc);
        for (int c = cyc + 1; c < MAXC; c++) e_lk[c] = 0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        for (int c = 0; c < MAXC; c++) begin
            e_ena[c] = 0; e_addr[c] = 0; e_seq[c] = 0; e_sel[c] = 0;
            e_done[c] = 0; e_busy[c] = 0; e_ready[c] = 1; e_lk[c] = 0;
        end
        repeat (4) step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_ena", cb_ena, 0);
        rst_n = 1'b1;

        cmd(1, 1, 'h010, 3, 0, 0, t);
        chk("a_addr0", cb_addra, 'h010);
        chk("a_seq0", seq_cnt, 0);
        goto(t + 3);
        chk("a_addr2", cb_addra, 'h012);
        chk("a_seq2", seq_cnt, 2);
        chk("a_sel_first", sel, 5'b00101);
        goto(t + 5);
        chk("a_sel_last", sel, 5'b00101);
        goto(t + 6);
        chk("a_done", done, 1);
        chk("a_sel_off", sel, 0);

        cmd(4, 3, 'h100, 9, 1, 0, t);
        goto(t + 3);
        chk("tba_sel", sel, 5'b10011);
        goto(t + 5);
        chk("tba_seq4", seq_cnt, 4);
        chk("tba_addr4", cb_addra, 'h104);
        goto(t + 6);
        chk("tba_ena_off", cb_ena, 0);
        goto(t + 7);
        chk("tba_sel_last", sel, 5'b10011);
        goto(t + 8);
        chk("tba_done", done, 1);
        goto(t + 9);
        chk("tba_lk_held", l_k_0, 1);

        cmd(2, 2, 'h3FE, 4, 0, 0, t);
        goto(t + 2);
        chk("wrap_3ff", cb_addra, 'h3FF);
        goto(t + 3);
        chk("wrap_000", cb_addra, 'h000);
        chk("wrap_sel", sel, 5'b01010);
        goto(t + 4);
        chk("wrap_001", cb_addra, 'h001);

        cmd(3, 1, 'h055, 0, 0, 0, t);
        chk("len0_done", done, 1);
        chk("len0_ena", cb_ena, 0);

        cmd(7, 1, 'h020, 2, 1, 0, t);
        cmd(0, 0, 'h030, 1, 0, 0, t);

        cmd(1, 2, 'h040, 1, 0, 0, t);
        goto(t + 4);
        chk("dn_done", done, 1);
        do_abort();
        chk("dn_abort_ready", cmd_ready, 1);

        cmd(2, 1, 'h080, 6, 1, 0, t);
        goto(t + 2);
        do_abort();
        chk("ab_ena", cb_ena, 0);
        chk("ab_busy", busy, 0);
        goto(t + 6);
        chk("ab_sel", sel, 0);
        cmd(1, 3, 'h090, 2, 0, 1, t);
        chk("ab_newcmd_addr", cb_addra, 'h090);

        cmd(3, 2, 'h0A0, 3, 1, 0, t);
        goto(t + 4);
        do_reset();
        chk("rs_ena", cb_ena, 0);
        chk("rs_lk", l_k_0, 0);
        chk("rs_ready", cmd_ready, 1);

        cmd(1, 1, 'h001, 2, 0, 0, t);
        goto(t + 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
